// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 4-word register window, TX FIFO and 8N1 serialiser.
// Optional even-parity bit enabled by defining UART_PARITY_EN.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'd1020,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataBusOut,
  input  logic [2:0]  ControlBus,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [31:0] offset;
  logic        wr_en, rd_en;
  logic        wr_txdata, wr_status, wr_baud;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        full, empty, push, pop, ovf_set;
  logic        overflow;
  logic [15:0] baud;
  logic [3:0]  count_sat;
  logic [31:0] status;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, div_frame;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg;
  logic        load, shift, bit_done;
  logic        par;

  logic        unused_bits;
  assign unused_bits = ^{ControlBus[0], DataBusOut[31:16]};

  // Address decode: the subtraction wraps, so one compare covers the whole window
  assign offset    = AddressBus - BASE_ADDR;
  assign sel       = (offset[31:2] == 30'd0);
  assign wr_en     = sel & ControlBus[2];
  assign rd_en     = sel & ControlBus[1];
  assign wr_txdata = wr_en && (offset[1:0] == 2'd0);
  assign wr_status = wr_en && (offset[1:0] == 2'd1);
  assign wr_baud   = wr_en && (offset[1:0] == 2'd2);

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (wptr == rptr);
  assign push    = wr_txdata && (!full || pop);
  assign ovf_set = wr_txdata && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= DataBusOut[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      baud     <= DEFAULT_DIV;
      irq      <= 1'b1;
    end else begin
      if (wr_status)    overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      if (wr_baud) baud <= (DataBusOut[15:0] == 16'd0) ? 16'd1 : DataBusOut[15:0];
      irq <= empty && (state == IDLE);
    end
  end

  // Transmit FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      div_frame <= DEFAULT_DIV;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      if (load) div_frame <= baud;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= mem[rptr[AW-1:0]];
      par   <= ^mem[rptr[AW-1:0]];
    end else if (shift) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  assign bit_done = (cnt == div_frame - 16'd1);

  // Transmit FSM: next state; STOP pops directly so back-to-back frames have no gap
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    pop     = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          shift = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      PARITY:  tx = par;
      default: tx = 1'b1;
    endcase
  end

  assign count_sat = (32'(count) > 32'd15) ? 4'd15 : 4'(count);
  assign status    = {20'd0, count_sat, 3'd0, PAR_FLAG, overflow, (state != IDLE), empty, full};

  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      case (offset[1:0])
        2'd1:    rdata = status;
        2'd2:    rdata = {16'd0, baud};
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter attached downstream of the single-cycle CPU's data bus, alongside data memory. It decodes CPU stores and loads in a 4-word window, buffers transmit bytes in a FIFO, and serialises them as 8N1 frames on a TX pin. Read data is returned combinationally in the same cycle, so it can feed the CPU's `DataBusIn` mux without stalls. Clocked from the free-running board clock, so queued bytes keep draining after the CPU halts.

## Interface
- `BASE_ADDR`, default 32'd1020: word address of register 0. The window is `BASE_ADDR`..`BASE_ADDR+3`.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of 2, ≥2.
- `DEFAULT_DIV`, default 16'd16: reset value of `BAUD_DIV` (clocks per bit).

Ports:
- `clk` in 1: free-running clock (the CPU's `InputClk`, not the halt-gated clock).
- `rst` in 1: reset, synchronous and active-low. `rst==0` at a rising edge resets all state.
- `AddressBus` in 32: CPU word address (ALU result).
- `DataBusOut` in 32: CPU store data.
- `ControlBus` in 3: `{MemWriteEn, MemReadEn, RegWriteEn}`.
- `sel` out 1: combinational. High when `AddressBus` is inside the window.
- `rdata` out 32: combinational read data. 0 when `sel==0` or `MemReadEn==0`.
- `tx` out 1: serial output, idle high.
- `irq` out 1: registered. High while the FIFO is empty and the shifter is idle.

## Operation
Register map (offset from `BASE_ADDR`):
- **+0 TXDATA**
  - Write pushes `DataBusOut[7:0]`.
  - Reads return 0.
- **+1 STATUS** (read)
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
  - [11:8] FIFO count, saturating at 15.
  - Any write clears overflow.
- **+2 BAUD_DIV**
  - R/W [15:0]. A written value of 0 is stored as 1.
  - Upper read bits are 0.
- **+3** reserved: reads 0, writes ignored.

Rules:
- A write is `sel && MemWriteEn`, committed at the rising edge.
- Push to a full FIFO: byte dropped, overflow set, FIFO unchanged.
- FIFO: circular read/write pointers, log2(`FIFO_DEPTH`)+1 bits each, so full and empty are unambiguous at wrap-around.
- A push and a pop in the same cycle are both honoured; count is unchanged.
- Push when count==`FIFO_DEPTH`-1 and a pop also occurs: accepted (not full after the pop).

TX FSM, with a 16-bit baud counter and 3-bit bit index:
- **IDLE**: if FIFO is non-empty, pop into the shift register, latch `BAUD_DIV` into the frame divider, and go to START.
- **START**: `tx=0` for div cycles, then go to DATA.
- **DATA**: send LSB first, div cycles per bit. After bit 7, go to STOP (or PARITY, see Configuration).
- **STOP**: `tx=1` for div cycles, then go to IDLE.
- A `BAUD_DIV` write mid-frame takes effect from the next frame only.

Reset values:
- `tx`=1, `irq`=1, FSM=IDLE, FIFO empty, overflow=0, `BAUD_DIV`=`DEFAULT_DIV`.
- Reset mid-frame aborts it: `tx`=1 after that edge and queued bytes are discarded.

## Timing
- A TXDATA write committed at edge N into an empty FIFO with FSM in IDLE:
  - pop at edge N+1;
  - `tx` falls after N+1;
  - start bit lasts div cycles;
  - full frame is 10×div cycles.
- Back-to-back frames: the next start bit begins the cycle after the stop bit ends (one IDLE cycle only if the FIFO was empty).
- STATUS reflects state registered at the previous edge; a write in cycle N is visible to a read in cycle N+1.
- `irq` is registered, so it drops one edge after the push edge.

## Configuration
- **`UART_PARITY_EN`**
  - Defined: adds a PARITY state between DATA and STOP that sends even parity (XOR of the 8 data bits) for div cycles. Frame becomes 11×div cycles. STATUS bit4 reads 1.
  - Undefined: 8N1, 10×div-cycle frame, STATUS bit4 reads 0.

## Test plan
- **Single byte**
  - Stimulus: reset, write BAUD_DIV=4, write TXDATA=8'hA5.
  - Response: `tx` low 4 cycles; then 1,0,1,0,0,1,0,1 for 4 cycles each; high 4 cycles; STATUS empty=1 and `irq`=1 after 40 cycles.
- **Fill and overflow**
  - Stimulus: div=100, push 10 bytes back-to-back.
  - Response: first pops immediately, next 8 fill the FIFO, 10th sets overflow. STATUS reads full=1, overflow=1, count=8. A STATUS write clears overflow.
- **Simultaneous push/pop at full**
  - Stimulus: push a byte on the exact edge where IDLE pops.
  - Response: byte accepted, count unchanged, no overflow.
- **Pointer wrap**
  - Stimulus: div=1, stream 20 bytes 0x00..0x13.
  - Response: received in order with no loss.
- **Mid-frame reset / divider change**
  - Stimulus: assert `rst`=0 during bit 3.
  - Response: `tx`=1 the next cycle; STATUS=empty; BAUD_DIV=16.
  - Stimulus: write BAUD_DIV=0.
  - Response: reads back 1.
- **Parity** (`UART_PARITY_EN` defined)
  - Stimulus: byte 8'h07, div=2.
  - Response: parity bit 1 for 2 cycles before stop; frame is 22 cycles.
